clk_monitor: RTL and testbench

- Receive-side counterpart to the team's clock generator. Observes an asynchronous monitored clock (`mon_clk`) in the system `clk` domain.
- Measures each `mon_clk` period in `clk` cycles and checks it against an expected window.
- Tracks lock status and flags too-fast, too-slow and stuck-clock faults.
- Used in benches and in on-chip health logic to confirm a generated clock is present and at the right rate.

---
 rtl/clk_monitor.sv | 222 ++++++++++++++++++++++
 tb/tb_clk_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_monitor.sv
// Measures each period of an asynchronous mon_clk in clk cycles and flags fast, slow and stuck faults.
// Define CLK_MON_DUTY_EN to add high-time measurement (high_meas) and duty-cycle checking (err_duty).
`timescale 1ns/1ps
module clk_monitor #(
  parameter int CW       = 16,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk,
  input  logic             enable,
  input  logic [CW-1:0]    exp_period,
  input  logic [CW-1:0]    tol,
  output logic [CW-1:0]    period_meas,
  output logic             period_valid,
  output logic             locked,
  output logic             err_fast,
  output logic             err_slow,
  output logic             err_stuck,
`ifdef CLK_MON_DUTY_EN
  output logic [CW-1:0]    high_meas,
  output logic             err_duty,
`endif
  output logic [ERR_W-1:0] err_count
);

  // state     | meaning
  // IDLE      | monitoring disabled, counters held at zero
  // WAIT_EDGE | waiting for the first mon_clk edge to start a period
  // MEASURE   | measuring periods, counting in-window periods toward lock
  // LOCKED    | LOCK_CNT consecutive periods in window, still measuring
  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, LOCKED} state_t;

  localparam int GW = $clog2(LOCK_CNT + 1);

  state_t           state, state_nxt;
  logic             sync1, sync2, sync3;
  logic             rise;
  logic [CW-1:0]    cnt, cnt_nxt, cnt_sat;
  logic [GW-1:0]    good, good_nxt;
  logic [CW-1:0]    meas_nxt;
  logic             locked_nxt, pv_nxt, fast_nxt, slow_nxt, stuck_nxt;
  logic [CW:0]      win_lo, win_hi, meas_ext;
  logic             is_fast, is_slow;
  logic [CW+1:0]    cnt_p1, stuck_thr;
  logic             stuck_hit;
  logic             duty_evt;
  logic [1:0]       ev_cnt;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] err_count_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= mon_clk;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

  // cnt+1 is the period ending at this rise; it doubles as the saturating increment
  assign cnt_sat   = (cnt == '1) ? cnt : cnt + 1'b1;
  assign win_hi    = {1'b0, exp_period} + {1'b0, tol};
  assign win_lo    = (tol > exp_period) ? '0 : {1'b0, exp_period - tol};
  assign meas_ext  = {1'b0, cnt_sat};
  assign is_fast   = meas_ext < win_lo;
  assign is_slow   = meas_ext > win_hi;
  assign cnt_p1    = {2'b00, cnt} + (CW+2)'(1);
  assign stuck_thr = {exp_period, 2'b00};
  assign stuck_hit = cnt_p1 >= stuck_thr;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    good_nxt   = good;
    meas_nxt   = period_meas;
    locked_nxt = locked;
    pv_nxt     = 1'b0;
    fast_nxt   = 1'b0;
    slow_nxt   = 1'b0;
    stuck_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt    = '0;
        good_nxt   = '0;
        locked_nxt = 1'b0;
        if (enable) state_nxt = WAIT_EDGE;
      end
      WAIT_EDGE: begin
        cnt_nxt    = '0;
        locked_nxt = 1'b0;
        if (rise) begin
          good_nxt  = '0;
          state_nxt = MEASURE;
        end
      end
      MEASURE, LOCKED: begin
        cnt_nxt = cnt_sat;
        if (rise) begin
          cnt_nxt  = '0;
          meas_nxt = cnt_sat;
          pv_nxt   = 1'b1;
          if (is_fast || is_slow) begin
            fast_nxt   = is_fast;
            slow_nxt   = is_slow;
            good_nxt   = '0;
            locked_nxt = 1'b0;
            state_nxt  = MEASURE;
          end else if (state == MEASURE) begin
            if (good >= GW'(LOCK_CNT - 1)) begin
              good_nxt   = '0;
              locked_nxt = 1'b1;
              state_nxt  = LOCKED;
            end else begin
              good_nxt = good + 1'b1;
            end
          end
        end else if (stuck_hit) begin
          stuck_nxt  = 1'b1;
          locked_nxt = 1'b0;
          good_nxt   = '0;
          cnt_nxt    = '0;
          state_nxt  = WAIT_EDGE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // disable overrides everything and drops any pulse computed this cycle
    if (!enable) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      good_nxt   = '0;
      meas_nxt   = period_meas;
      locked_nxt = 1'b0;
      pv_nxt     = 1'b0;
      fast_nxt   = 1'b0;
      slow_nxt   = 1'b0;
      stuck_nxt  = 1'b0;
    end
    ev_cnt        = {1'b0, fast_nxt} + {1'b0, slow_nxt} + {1'b0, stuck_nxt} + {1'b0, duty_evt};
    err_sum       = {1'b0, err_count} + {{(ERR_W-1){1'b0}}, ev_cnt};
    err_count_nxt = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      good         <= '0;
      period_meas  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_fast     <= 1'b0;
      err_slow     <= 1'b0;
      err_stuck    <= 1'b0;
      err_count    <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      good         <= good_nxt;
      period_meas  <= meas_nxt;
      period_valid <= pv_nxt;
      locked       <= locked_nxt;
      err_fast     <= fast_nxt;
      err_slow     <= slow_nxt;
      err_stuck    <= stuck_nxt;
      err_count    <= err_count_nxt;
    end
  end

`ifdef CLK_MON_DUTY_EN
  logic [CW-1:0] hcnt, hcnt_nxt, high_nxt, high_sat;
  logic [CW+1:0] high_x4, per_x1, per_x3;
  logic          duty_nxt;

  // hcnt is cleared in the rise cycle, so the rise cycle itself is added back here
  assign high_sat = (hcnt == '1) ? hcnt : hcnt + 1'b1;
  assign high_x4  = {high_sat, 2'b00};
  assign per_x1   = {2'b00, cnt_sat};
  assign per_x3   = per_x1 + {1'b0, cnt_sat, 1'b0};

  always_comb begin
    hcnt_nxt = hcnt;
    high_nxt = high_meas;
    duty_nxt = 1'b0;
    if (!enable || state == IDLE || state == WAIT_EDGE) begin
      hcnt_nxt = '0;
    end else if (rise) begin
      hcnt_nxt = '0;
      high_nxt = high_sat;
      duty_nxt = (high_x4 < per_x1) || (high_x4 > per_x3);
    end else if (stuck_hit) begin
      hcnt_nxt = '0;
    end else if (sync2 && hcnt != '1) begin
      hcnt_nxt = hcnt + 1'b1;
    end
  end

  assign duty_evt = duty_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt      <= '0;
      high_meas <= '0;
      err_duty  <= 1'b0;
    end else begin
      hcnt      <= hcnt_nxt;
      high_meas <= high_nxt;
      err_duty  <= duty_nxt;
    end
  end
`else
  assign duty_evt = 1'b0;
`endif

endmodule

// File: tb/tb_clk_monitor.sv
// Scoreboard bench for clk_monitor: mon_clk edges are driven with directed timing, the expected
// response for each edge is queued, and a negedge monitor compares every output event.
`timescale 1ns/1ps
module tb_clk_monitor;
  localparam int CW    = 16;
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             mon_clk;
  logic             enable;
  logic [CW-1:0]    exp_period;
  logic [CW-1:0]    tol;
  logic [CW-1:0]    period_meas;
  logic             period_valid;
  logic             locked;
  logic             err_fast;
  logic             err_slow;
  logic             err_stuck;
  logic [ERR_W-1:0] err_count;
`ifdef CLK_MON_DUTY_EN
  logic [CW-1:0]    high_meas;
  logic             err_duty;
`endif

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint last_evt = -1;
  logic   any_evt;

  typedef struct {
    int period;
    bit fast;
    bit slow;
    bit stuck;
    bit lockd;
    int errc;
    int high;
    bit duty;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_cur;

  clk_monitor #(.CW(CW), .LOCK_CNT(4), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .mon_clk     (mon_clk),
    .enable      (enable),
    .exp_period  (exp_period),
    .tol         (tol),
    .period_meas (period_meas),
    .period_valid(period_valid),
    .locked      (locked),
    .err_fast    (err_fast),
    .err_slow    (err_slow),
    .err_stuck   (err_stuck),
`ifdef CLK_MON_DUTY_EN
    .high_meas   (high_meas),
    .err_duty    (err_duty),
`endif
    .err_count   (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef CLK_MON_DUTY_EN
  assign any_evt = period_valid | err_fast | err_slow | err_stuck | err_duty;
`else
  assign any_evt = period_valid | err_fast | err_slow | err_stuck;
`endif

  function automatic void check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic exp_t mk(int period, bit fast, bit slow, bit stuck, bit lockd,
                              int errc, int high, bit duty, int gap);
    exp_t e;
    e.period = period; e.fast = fast; e.slow = slow; e.stuck = stuck; e.lockd = lockd;
    e.errc = errc; e.high = high; e.duty = duty; e.gap = gap;
    return e;
  endfunction

  task automatic mon_edge(int hi, int lo, bit push, exp_t e);
    if (push) exp_q.push_back(e);
    mon_clk = 1'b1;
    #(hi);
    mon_clk = 1'b0;
    #(lo);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_period_meas"}, period_meas, 0);
    check({tag, "_period_valid"}, period_valid, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err_fast"}, err_fast, 0);
    check({tag, "_err_slow"}, err_slow, 0);
    check({tag, "_err_stuck"}, err_stuck, 0);
    check({tag, "_err_count"}, err_count, 0);
`ifdef CLK_MON_DUTY_EN
    check({tag, "_high_meas"}, high_meas, 0);
    check({tag, "_err_duty"}, err_duty, 0);
`endif
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_evt = -1;
    end else if (any_evt) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        e_cur = exp_q.pop_front();
        check("period_valid", period_valid, !e_cur.stuck);
        check("period_meas", period_meas, e_cur.period);
        check("err_fast", err_fast, e_cur.fast);
        check("err_slow", err_slow, e_cur.slow);
        check("err_stuck", err_stuck, e_cur.stuck);
        check("locked", locked, e_cur.lockd);
        check("err_count", err_count, e_cur.errc);
`ifdef CLK_MON_DUTY_EN
        check("high_meas", high_meas, e_cur.high);
        check("err_duty", err_duty, e_cur.duty);
`endif
        if (e_cur.gap >= 0) check("event_gap", cyc - last_evt, e_cur.gap);
      end
      last_evt = cyc;
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: stimulus still running at t=%0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int errc0;
    int ec;
    rst = 1'b1; enable = 1'b0; mon_clk = 1'b0; exp_period = 10; tol = 1;
    #7;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    #7;
    #20;

    // lock at 100 ns
    mon_edge(50, 50, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, -1));
    for (int i = 1; i <= 4; i++)
      mon_edge(50, 50, 1, mk(10, 0, 0, 0, i == 4, 0, 5, 0, (i == 1) ? -1 : 10));
    // switch to 80 ns: one fast error, then relock with exp_period=8
    mon_edge(40, 40, 1, mk(10, 0, 0, 0, 1, 0, 5, 0, 10));
    mon_edge(40, 40, 1, mk(8, 1, 0, 0, 0, 1, 4, 0, 8));
    exp_period = 8;
    for (int i = 7; i <= 9; i++)
      mon_edge(40, 40, 1, mk(8, 0, 0, 0, 0, 1, 4, 0, 8));
    mon_edge(50, 50, 1, mk(8, 0, 0, 0, 1, 1, 4, 0, 8));
    exp_period = 10;
    mon_edge(50, 50, 1, mk(10, 0, 0, 0, 1, 1, 5, 0, 10));
    // stuck low after a locked period: err_stuck 40 cycles after the last period_valid
    exp_q.push_back(mk(10, 0, 0, 0, 1, 1, 5, 0, 10));
    exp_q.push_back(mk(10, 0, 0, 1, 0, 2, 5, 0, 40));
    mon_edge(50, 600, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, -1));
    // restart: first edge gives no measurement
    mon_edge(50, 50, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, -1));
    for (int i = 14; i <= 17; i++)
      mon_edge(50, 50, 1, mk(10, 0, 0, 0, i == 17, 2, 5, 0, (i == 14) ? -1 : 10));
    // asynchronous reset mid-period while locked
    exp_q.push_back(mk(10, 0, 0, 0, 1, 2, 5, 0, 10));
    mon_clk = 1'b1;
    #50;
    mon_clk = 1'b0;
    #20;
    check("queue_before_reset", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    #9;
    rst = 1'b0;
    #20;

`ifdef CLK_MON_DUTY_EN
    // 20% duty: err_duty each period, lock unaffected
    mon_edge(20, 80, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, -1));
    for (int i = 1; i <= 4; i++)
      mon_edge((i == 4) ? 50 : 20, (i == 4) ? 50 : 80, 1,
               mk(10, 0, 0, 0, i == 4, i, 2, 1, (i == 1) ? -1 : 10));
    mon_edge(60, 60, 1, mk(10, 0, 0, 0, 1, 4, 5, 0, 10));
    errc0 = 4;
`else
    mon_edge(60, 60, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, -1));
    errc0 = 0;
`endif

    // 120 ns: repeated slow errors, err_count saturates at 255
    for (int i = 1; i <= 260; i++) begin
      ec = (errc0 + i > 255) ? 255 : errc0 + i;
      mon_edge((i == 260) ? 50 : 60, (i == 260) ? 50 : 60, 1,
               mk(12, 0, 1, 0, 0, ec, 6, 0, (i == 1) ? -1 : 12));
    end
    for (int j = 1; j <= 4; j++)
      mon_edge(50, 50, 1, mk(10, 0, 0, 0, j == 4, 255, 5, 0, 10));

    // enable low mid-lock: IDLE next cycle, err_count and period_meas held
    exp_q.push_back(mk(10, 0, 0, 0, 1, 255, 5, 0, 10));
    mon_clk = 1'b1;
    #50;
    mon_clk = 1'b0;
    #20;
    check("locked_before_disable", locked, 1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("disable_locked", locked, 0);
    check("disable_err_count", err_count, 255);
    check("disable_period_meas", period_meas, 10);
    #6;
    for (int k = 0; k < 3; k++)
      mon_edge(50, 50, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, -1));
    check("disabled_err_count", err_count, 255);
    check("disabled_locked", locked, 0);
    enable = 1'b1;
    #30;
    mon_edge(50, 50, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, -1));
    mon_edge(50, 50, 1, mk(10, 0, 0, 0, 0, 255, 5, 0, -1));

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
